// File: rtl/samp_rate_pkg.sv
// Shared constants for the sample-rate detector: rate indices, period widths,
// the FSM state type and the nominal period table derived from the clock rate.
package samp_rate_pkg;

  localparam int                  PERIOD_W   = 14;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = 14'd16383;
  localparam int                  NUM_RATES  = 8;
  localparam int unsigned         CLK_HZ_DEF = 60_000_000;

  localparam logic [2:0] IDX_48K    = 3'd7;
  localparam logic [2:0] IDX_44K1   = 3'd6;
  localparam logic [2:0] IDX_32K    = 3'd5;
  localparam logic [2:0] IDX_24K    = 3'd4;
  localparam logic [2:0] IDX_22K05  = 3'd3;
  localparam logic [2:0] IDX_16K    = 3'd2;
  localparam logic [2:0] IDX_11K025 = 3'd1;
  localparam logic [2:0] IDX_8K     = 3'd0;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;

  // Lower rates are exact multiples of their family base period, so the
  // truncated 44.1k base propagates (2720, 5440 rather than 2721, 5442).
  function automatic logic [PERIOD_W-1:0] nom_period(input int unsigned clk_hz,
                                                     input int unsigned k);
    int unsigned p48, p441, p32, p;
    p48  = clk_hz / 48000;
    p441 = clk_hz / 44100;
    p32  = clk_hz / 32000;
    case (k)
      7:       p = p48;
      6:       p = p441;
      5:       p = p32;
      4:       p = 2 * p48;
      3:       p = 2 * p441;
      2:       p = 2 * p32;
      1:       p = 4 * p441;
      default: p = 4 * p32;
    endcase
    return p[PERIOD_W-1:0];
  endfunction

  localparam logic [PERIOD_W-1:0] NOM_PERIOD [NUM_RATES] = '{
    nom_period(CLK_HZ_DEF, 0), nom_period(CLK_HZ_DEF, 1),
    nom_period(CLK_HZ_DEF, 2), nom_period(CLK_HZ_DEF, 3),
    nom_period(CLK_HZ_DEF, 4), nom_period(CLK_HZ_DEF, 5),
    nom_period(CLK_HZ_DEF, 6), nom_period(CLK_HZ_DEF, 7)
  };

endpackage

// File: rtl/samp_rate_classify.sv
// Combinational period classifier: flags a match when the period lies within
// NOM>>6 of one nominal period and returns that rate's strobe-bus index.
module samp_rate_classify
  import samp_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_match,
  output logic [2:0]          o_idx
);

  logic [NUM_RATES-1:0][PERIOD_W-1:0] w_diff;
  logic [NUM_RATES-1:0]               w_hit;

  genvar k;
  for (k = 0; k < NUM_RATES; k++) begin : g_cmp
    localparam logic [PERIOD_W-1:0] NOM = nom_period(CLK_HZ, k);
    assign w_diff[k] = (i_period >= NOM) ? (i_period - NOM) : (NOM - i_period);
    assign w_hit[k]  = (w_diff[k] <= (NOM >> 6));
  end

  // Tolerance windows never overlap, so at most one hit bit is set.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_RATES; i++)
      if (w_hit[i]) o_idx = 3'(i);
  end

  assign o_match = |w_hit;

endmodule

// File: rtl/samp_rate_detector.sv
// Sample-rate detector: measures the period of samp_in and locks onto one of
// eight audio rates. Define SAMP_DET_AVG4_EN to classify a 4-period mean.
module samp_rate_detector
  import samp_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                samp_in,
  output logic [2:0]          rate_idx,
  output logic                rate_valid,
  output logic                rate_chg,
  output logic                meas_stb,
  output logic [PERIOD_W-1:0] period_out
);

  localparam logic [3:0]          LOCK_N = 4'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] CNT_ONE = 14'd1;

  logic [2:0]          r_sync;
  logic [PERIOD_W-1:0] r_cnt;
  state_e              r_state;
  logic [3:0]          r_match_cnt;
  logic [2:0]          r_last_idx;
  logic [2:0]          r_idx;
  logic                r_stb;
  logic [PERIOD_W-1:0] r_period;
  logic [3:0]          r_prev;
  logic                r_chg;

  logic                w_edge;
  logic                w_sat;
  logic [PERIOD_W-1:0] w_meas;
  logic                w_ready;
  logic                w_match;
  logic [2:0]          w_idx;
  logic                w_cls;
  logic                w_same;
  logic [3:0]          w_cnt_nxt;

  assign w_edge = r_sync[1] & ~r_sync[2];
  assign w_sat  = (r_cnt == PERIOD_MAX);

`ifdef SAMP_DET_AVG4_EN
  logic [2:0][PERIOD_W-1:0] r_hist;
  logic [1:0]               r_hcnt;
  logic [15:0]              w_sum;

  assign w_sum   = {2'b00, r_cnt} + {2'b00, r_hist[0]} +
                   {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
  assign w_meas  = w_sum[15:2];
  assign w_ready = (r_hcnt == 2'd3);

  // History holds the three previous periods; it restarts whenever we idle.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_hcnt <= '0;
    end else if (r_state == IDLE || (!w_edge && w_sat)) begin
      r_hist <= '0;
      r_hcnt <= '0;
    end else if (w_edge) begin
      r_hist <= {r_hist[1:0], r_cnt};
      if (r_hcnt != 2'd3) r_hcnt <= r_hcnt + 2'd1;
    end
  end
`else
  assign w_meas  = r_cnt;
  assign w_ready = 1'b1;
`endif

  samp_rate_classify #(.CLK_HZ(CLK_HZ)) u_cls (
    .i_period (w_meas),
    .o_match  (w_match),
    .o_idx    (w_idx)
  );

  // A period that hit saturation is never a valid rate, even when averaged.
  assign w_cls     = w_match & ~w_sat & w_ready;
  assign w_same    = (r_match_cnt != 4'd0) && (w_idx == r_last_idx);
  assign w_cnt_nxt = !w_cls ? 4'd0 : (w_same ? r_match_cnt + 4'd1 : 4'd1);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync      <= '0;
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_match_cnt <= '0;
      r_last_idx  <= '0;
      r_idx       <= '0;
      r_stb       <= 1'b0;
      r_period    <= '0;
      r_prev      <= '0;
      r_chg       <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], samp_in};
      r_stb  <= 1'b0;
      r_cnt  <= w_edge ? CNT_ONE : (w_sat ? r_cnt : r_cnt + CNT_ONE);
      if (w_edge) begin
        case (r_state)
          IDLE: r_state <= MEASURE;
          MEASURE: begin
            r_stb    <= 1'b1;
            r_period <= w_meas;
            if (w_ready) begin
              r_match_cnt <= w_cnt_nxt;
              r_last_idx  <= w_idx;
              if (w_cnt_nxt >= LOCK_N) begin
                r_state <= LOCKED;
                r_idx   <= w_idx;
              end
            end
          end
          LOCKED: begin
            r_stb    <= 1'b1;
            r_period <= w_meas;
            if (!(w_cls && w_idx == r_idx)) begin
              r_state     <= MEASURE;
              r_match_cnt <= w_cls ? 4'd1 : 4'd0;
              r_last_idx  <= w_idx;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_sat) begin
        r_state     <= IDLE;
        r_match_cnt <= '0;
      end
      r_prev <= {rate_valid, r_idx};
      r_chg  <= ({rate_valid, r_idx} != r_prev);
    end
  end

  assign rate_valid = (r_state == LOCKED);
  assign rate_idx   = r_idx;
  assign rate_chg   = r_chg;
  assign meas_stb   = r_stb;
  assign period_out = r_period;

endmodule
